// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: default sizes, a constant-foldable
// clog2, and Gray-code converters used by the dual-clock members.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Smallest r with 2**r >= v; usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/fifo_mem_1r1w.sv
// WIDTH x DEPTH storage array: synchronous write port, asynchronous read port.
module fifo_mem_1r1w #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store one word per accepted write; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, programmable almost-full/empty thresholds,
// optional first-word-fall-through output and sticky overflow/underflow flags.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   err_clr
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("sync_fifo_flags: DEPTH must be a power of 2 and >= 2");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_chk_levels
    $error("sync_fifo_flags: AE_LEVEL must be below AF_LEVEL");
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [WIDTH-1:0] mem_rdata;
  logic             wr_acc;
  logic             rd_acc;

  // Every flag is a function of the pointer registers only.
  assign full         = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty        = (wr_ptr == rd_ptr);
  assign count        = CNT_W'(wr_ptr - rd_ptr);
  assign almost_full  = (count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count <= CNT_W'(AE_LEVEL));

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Write is gated by reset so a push coinciding with reset never lands.
  fifo_mem_1r1w #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc & rst_n),
    .waddr (wr_ptr[PTR_W-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[PTR_W-1:0]),
    .rdata (mem_rdata)
  );

  // Advance pointers on accepted pushes and pops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky error flags; a new rejection takes priority over err_clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)       overflow <= 1'b1;
      else if (err_clr)        overflow <= 1'b0;
      if (rd_en && empty)      underflow <= 1'b1;
      else if (err_clr)        underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head of queue is presented directly; rd_en acts as the pop.
    assign rd_data  = mem_rdata;
    assign rd_valid = ~empty;
  end else begin : g_reg
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    // Capture the popped word; valid pulses for the cycle after the pop.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem_rdata;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule
